pio_access_ctrl: RTL and testbench

//  Sequences host register accesses onto the PIO timing controller and the ATA address/data pins.

---
 rtl/pio_access_ctrl_if.sv | 12 +
 rtl/pio_access_ctrl.sv | 127 ++++++++++++
 tb/tb_pio_access_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_access_ctrl_if.sv
// pio_access_ctrl_if: host request/response channel of the PIO access controller
interface pio_access_ctrl_if;
  logic        req;
  logic        req_we;
  logic [3:0]  req_adr;
  logic [15:0] req_dat;
  logic        ack;
  logic        err;
  logic [15:0] rdat;
  modport master (output req, req_we, req_adr, req_dat, input ack, err, rdat);
  modport slave  (input req, req_we, req_adr, req_dat, output ack, err, rdat);
endinterface

// File: rtl/pio_access_ctrl.sv
// pio_access_ctrl: sequences host register accesses onto the PIO timing controller and ATA pins
module pio_access_ctrl #(
  parameter int TWIDTH         = 8,
  parameter int PIO_MODE0_T1   = 6,
  parameter int PIO_MODE0_T2   = 28,
  parameter int PIO_MODE0_T4   = 2,
  parameter int PIO_MODE0_Teoc = 23,
  parameter int TOUT_W         = 12
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                rst,
  pio_access_ctrl_if.slave    host,
  input  logic [1:0]          cfg_fast_en,
  input  logic [1:0]          cfg_iordy_en,
  input  logic [4*TWIDTH-1:0] tim_dev0,
  input  logic [4*TWIDTH-1:0] tim_dev1,
  output logic                pio_go,
  output logic                pio_we,
  output logic                pio_rst,
  output logic [TWIDTH-1:0]   pio_T1,
  output logic [TWIDTH-1:0]   pio_T2,
  output logic [TWIDTH-1:0]   pio_T4,
  output logic [TWIDTH-1:0]   pio_Teoc,
  output logic                pio_iordy_en,
  input  logic                pio_done,
  input  logic                pio_dstrb,
  output logic [2:0]          DA,
  output logic                CS0n,
  output logic                CS1n,
  output logic [15:0]         DDo,
  input  logic [15:0]         DDi,
  output logic                dev_sel
);
  typedef enum logic [2:0] {IDLE, SETUP, GO, WAIT, ABORT} state_t;
  typedef struct packed {
    state_t              st;
    logic [2:0]          da;
    logic                cs0n;
    logic                cs1n;
    logic [15:0]         ddo;
    logic                we;
    logic [4*TWIDTH-1:0] tim;
    logic                iordy;
    logic [TOUT_W-1:0]   wd;
    logic                ack;
    logic                err;
    logic [15:0]         rdat;
    logic                dev_sel;
  } regs_t;
  localparam logic [4*TWIDTH-1:0] MODE0 = {TWIDTH'(PIO_MODE0_Teoc), TWIDTH'(PIO_MODE0_T4),
                                           TWIDTH'(PIO_MODE0_T2), TWIDTH'(PIO_MODE0_T1)};
  localparam regs_t RST = '{st: IDLE, da: 3'd0, cs0n: 1'b1, cs1n: 1'b1, ddo: 16'd0, we: 1'b0,
                            tim: MODE0, iordy: 1'b0, wd: '0, ack: 1'b0, err: 1'b0,
                            rdat: 16'd0, dev_sel: 1'b0};
  regs_t             regs_q, regs_d;
  logic              init_q;
  logic [TOUT_W-1:0] wd_inc;
  logic [3:0]        adr;
  logic              fast;
  // Next state: the ATA pins and timing set are latched on acceptance so they are valid throughout SETUP
  always_comb begin
    regs_d = regs_q;
    regs_d.ack = 1'b0;
    regs_d.err = 1'b0;
    wd_inc = regs_q.wd + 1'b1;
    adr = {~regs_q.cs1n, regs_q.da};
    fast = (host.req_adr == 4'b0000) & cfg_fast_en[regs_q.dev_sel];
    case (regs_q.st)
      IDLE: if (host.req && !regs_q.ack) begin
        regs_d.st = SETUP;
        regs_d.da = host.req_adr[2:0];
        regs_d.cs1n = ~host.req_adr[3];
        regs_d.cs0n = host.req_adr[3];
        regs_d.ddo = host.req_dat;
        regs_d.we = host.req_we;
        regs_d.tim = fast ? (regs_q.dev_sel ? tim_dev1 : tim_dev0) : MODE0;
        regs_d.iordy = cfg_iordy_en[regs_q.dev_sel];
      end
      SETUP: regs_d.st = GO;
      GO: begin
        regs_d.st = WAIT;
        regs_d.wd = '0;
      end
      WAIT: begin
        regs_d.wd = wd_inc;
        if (pio_dstrb && !regs_q.we) regs_d.rdat = DDi;
        if (pio_done) begin
          regs_d.st = IDLE;
          regs_d.ack = 1'b1;
          if (regs_q.we && adr == 4'b0110) regs_d.dev_sel = regs_q.ddo[4];
          if (regs_q.we && adr == 4'b1110 && regs_q.ddo[2]) regs_d.dev_sel = 1'b0;
        end else if (&wd_inc) begin
          regs_d.st = ABORT;
          regs_d.ack = 1'b1;
          regs_d.err = 1'b1;
          regs_d.rdat = 16'd0;
        end
      end
      default: regs_d.st = IDLE;
    endcase
    if (rst) regs_d = RST;
  end
  // State registers; init_q marks the first cycle after nReset release
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      regs_q <= RST;
      init_q <= 1'b1;
    end else begin
      regs_q <= regs_d;
      init_q <= 1'b0;
    end
  end
  assign pio_go = regs_q.st == GO;
  assign pio_rst = init_q | rst | (regs_q.st == ABORT);
  assign pio_we = regs_q.we;
  assign {pio_Teoc, pio_T4, pio_T2, pio_T1} = regs_q.tim;
  assign pio_iordy_en = regs_q.iordy;
  assign DA = regs_q.da;
  assign CS0n = regs_q.cs0n;
  assign CS1n = regs_q.cs1n;
  assign DDo = regs_q.ddo;
  assign dev_sel = regs_q.dev_sel;
  assign host.ack = regs_q.ack;
  assign host.err = regs_q.err;
  assign host.rdat = regs_q.rdat;
endmodule

// File: tb/tb_pio_access_ctrl.sv
// tb_pio_access_ctrl: vector table, corner sequences and random accesses against a spec-level model
module tb_pio_access_ctrl;
  logic        clk, nReset, rst;
  logic [1:0]  cfg_fast_en, cfg_iordy_en;
  logic [31:0] tim_dev0, tim_dev1;
  logic        pio_go, pio_we, pio_rst, pio_iordy_en, pio_done, pio_dstrb;
  logic [7:0]  pio_T1, pio_T2, pio_T4, pio_Teoc;
  logic [2:0]  DA;
  logic        CS0n, CS1n, dev_sel;
  logic [15:0] DDo, DDi, ddi_v;
  logic        stall, stray_done, stray_dstrb;
  int          cnt;
  int          checks, errors;
  logic        m_dev;
  logic [15:0] m_rdat;
  localparam logic [31:0] MODE0 = 32'h17021C06;
  pio_access_ctrl_if h();
  pio_access_ctrl dut (
    .clk(clk), .nReset(nReset), .rst(rst), .host(h),
    .cfg_fast_en(cfg_fast_en), .cfg_iordy_en(cfg_iordy_en),
    .tim_dev0(tim_dev0), .tim_dev1(tim_dev1),
    .pio_go(pio_go), .pio_we(pio_we), .pio_rst(pio_rst),
    .pio_T1(pio_T1), .pio_T2(pio_T2), .pio_T4(pio_T4), .pio_Teoc(pio_Teoc),
    .pio_iordy_en(pio_iordy_en), .pio_done(pio_done), .pio_dstrb(pio_dstrb),
    .DA(DA), .CS0n(CS0n), .CS1n(CS1n), .DDo(DDo), .DDi(DDi), .dev_sel(dev_sel)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Timing controller stand-in: cycle lasts T1+T2+T4 clks after go; stall models IORDY held low
  always @(posedge clk) begin
    if (pio_rst) cnt <= 0;
    else if (pio_go) cnt <= pio_T1 + pio_T2 + pio_T4;
    else if (cnt > 1 || (cnt == 1 && !stall)) cnt <= cnt - 1;
  end
  assign pio_done = (cnt == 1 && !stall) || stray_done;
  assign pio_dstrb = cnt == 2 || stray_dstrb;
  assign DDi = cnt == 2 ? ddi_v : ~ddi_v;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wait_ack(input int lim, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!h.ack && n < lim);
    if (!h.ack) n = -1;
  endtask
  task automatic access(input logic [3:0] adr, input logic we, input logic [15:0] dat,
                        input logic [15:0] ddi, input logic [31:0] etim, input int elat,
                        input logic edev);
    int n;
    logic eio;
    eio = cfg_iordy_en[m_dev];
    @(posedge clk);
    @(negedge clk);
    h.req = 1'b1;
    h.req_we = we;
    h.req_adr = adr;
    h.req_dat = dat;
    ddi_v = ddi;
    @(posedge clk);
    #1;
    chk("setup_da", DA, adr[2:0]);
    chk("setup_cs0n", CS0n, adr[3]);
    chk("setup_cs1n", CS1n, !adr[3]);
    chk("setup_ddo", DDo, dat);
    chk("setup_we", pio_we, we);
    chk("setup_tim", {pio_Teoc, pio_T4, pio_T2, pio_T1}, etim);
    chk("setup_iordy", pio_iordy_en, eio);
    wait_ack(5000, n);
    h.req = 1'b0;
    chk("latency", n < 0 ? 0 : n + 1, elat);
    chk("err", h.err, 1'b0);
    if (!we) chk("rdat", h.rdat, ddi);
    chk("dev_sel", dev_sel, edev);
    m_dev = edev;
    if (!we) m_rdat = ddi;
  endtask
  function automatic logic [31:0] m_tim(input logic [3:0] adr);
    return (adr == 4'h0 && cfg_fast_en[m_dev]) ? (m_dev ? tim_dev1 : tim_dev0) : MODE0;
  endfunction
  function automatic int m_lat(input logic [31:0] t);
    return 3 + int'(t[7:0]) + int'(t[15:8]) + int'(t[23:16]);
  endfunction
  function automatic logic m_next(input logic [3:0] adr, input logic we, input logic [15:0] dat);
    return (we && adr == 4'h6) ? dat[4] : (we && adr == 4'hE && dat[2]) ? 1'b0 : m_dev;
  endfunction
  typedef struct {
    logic [1:0]  fe;
    logic [3:0]  adr;
    logic        we;
    logic [15:0] dat;
    logic [15:0] ddi;
    logic [31:0] tim;
    int          lat;
    logic        dev;
  } vec_t;
  vec_t tbl[12];
  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int n, n2;
    logic [3:0] a;
    logic we;
    logic [15:0] d, di;
    logic [31:0] t;
    tbl[0]  = '{2'b00, 4'h7, 1'b0, 16'h0000, 16'h0050, MODE0,        39, 1'b0};
    tbl[1]  = '{2'b01, 4'h0, 1'b1, 16'h1234, 16'h0000, 32'h05010802, 14, 1'b0};
    tbl[2]  = '{2'b01, 4'h6, 1'b1, 16'h0010, 16'h0000, MODE0,        39, 1'b1};
    tbl[3]  = '{2'b01, 4'h0, 1'b0, 16'h0000, 16'hBEEF, MODE0,        39, 1'b1};
    tbl[4]  = '{2'b11, 4'h0, 1'b0, 16'h0000, 16'h1357, 32'h09030C04, 22, 1'b1};
    tbl[5]  = '{2'b11, 4'h0, 1'b1, 16'hAAAA, 16'h0000, 32'h09030C04, 22, 1'b1};
    tbl[6]  = '{2'b11, 4'hE, 1'b1, 16'h0004, 16'h0000, MODE0,        39, 1'b0};
    tbl[7]  = '{2'b11, 4'h0, 1'b0, 16'h0000, 16'h2468, 32'h05010802, 14, 1'b0};
    tbl[8]  = '{2'b11, 4'h6, 1'b0, 16'h0000, 16'h0010, MODE0,        39, 1'b0};
    tbl[9]  = '{2'b11, 4'h6, 1'b1, 16'h0010, 16'h0000, MODE0,        39, 1'b1};
    tbl[10] = '{2'b11, 4'hE, 1'b1, 16'h0000, 16'h0000, MODE0,        39, 1'b1};
    tbl[11] = '{2'b10, 4'h0, 1'b0, 16'h0000, 16'hC0DE, 32'h09030C04, 22, 1'b1};
    checks = 0;
    errors = 0;
    nReset = 1'b1;
    rst = 1'b0;
    h.req = 1'b0;
    h.req_we = 1'b0;
    h.req_adr = 4'h0;
    h.req_dat = 16'h0;
    cfg_fast_en = 2'b00;
    cfg_iordy_en = 2'b10;
    tim_dev0 = 32'h05010802;
    tim_dev1 = 32'h09030C04;
    ddi_v = 16'h0;
    stall = 1'b0;
    stray_done = 1'b0;
    stray_dstrb = 1'b0;
    m_dev = 1'b0;
    m_rdat = 16'h0;
    #1 nReset = 1'b0;
    #12;
    chk("rst_ack", h.ack, 1'b0);
    chk("rst_err", h.err, 1'b0);
    chk("rst_rdat", h.rdat, 16'h0);
    chk("rst_go_we", {pio_go, pio_we, pio_iordy_en, dev_sel}, 4'b0000);
    chk("rst_da_ddo", {DA, DDo}, 19'h0);
    chk("rst_cs", {CS0n, CS1n}, 2'b11);
    chk("rst_pio_rst", pio_rst, 1'b1);
    chk("rst_tim", {pio_Teoc, pio_T4, pio_T2, pio_T1}, MODE0);
    @(negedge clk);
    nReset = 1'b1;
    #1 chk("pio_rst_first_cycle", pio_rst, 1'b1);
    @(posedge clk);
    #1 chk("pio_rst_after_first", pio_rst, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cfg_fast_en = tbl[i].fe;
      access(tbl[i].adr, tbl[i].we, tbl[i].dat, tbl[i].ddi, tbl[i].tim, tbl[i].lat, tbl[i].dev);
    end
    @(posedge clk);
    @(negedge clk);
    stray_done = 1'b1;
    stray_dstrb = 1'b1;
    ddi_v = 16'hFFFF;
    @(posedge clk);
    #1;
    chk("stray_ack", h.ack, 1'b0);
    chk("stray_rdat", h.rdat, m_rdat);
    @(negedge clk);
    stray_done = 1'b0;
    stray_dstrb = 1'b0;
    @(posedge clk);
    #1 chk("stray_go", pio_go, 1'b0);
    @(negedge clk);
    h.req = 1'b1;
    h.req_we = 1'b0;
    h.req_adr = 4'h9;
    repeat (12) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("sync_rst_pio_rst", pio_rst, 1'b1);
    @(posedge clk);
    #1;
    chk("sync_rst_cs", {CS0n, CS1n}, 2'b11);
    chk("sync_rst_ack", h.ack, 1'b0);
    chk("sync_rst_dev", dev_sel, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    h.req = 1'b0;
    #1 chk("sync_rst_release", pio_rst, 1'b0);
    wait_ack(100, n);
    chk("no_ack_after_rst", n, -1);
    m_dev = 1'b0;
    m_rdat = 16'h0;
    access(4'h7, 1'b0, 16'h0, 16'h4A4A, MODE0, 39, 1'b0);
    cfg_fast_en = 2'b00;
    access(4'h1, 1'b0, 16'h0, 16'h0101, MODE0, 39, 1'b0);
    @(negedge clk);
    h.req = 1'b1;
    h.req_we = 1'b0;
    h.req_adr = 4'h2;
    ddi_v = 16'h0202;
    wait_ack(200, n);
    wait_ack(200, n2);
    h.req = 1'b0;
    chk("b2b_second_ack_gap", n2, 40);
    cfg_iordy_en = 2'b01;
    stall = 1'b1;
    @(posedge clk);
    @(negedge clk);
    h.req = 1'b1;
    h.req_adr = 4'h7;
    @(posedge clk);
    #1 chk("abort_iordy_en", pio_iordy_en, 1'b1);
    wait_ack(5000, n);
    chk("abort_latency", n < 0 ? 0 : n + 1, 4098);
    chk("abort_err", h.err, 1'b1);
    chk("abort_rdat", h.rdat, 16'h0);
    chk("abort_pio_rst", pio_rst, 1'b1);
    h.req = 1'b0;
    stall = 1'b0;
    @(posedge clk);
    #1 chk("abort_after", {pio_rst, h.ack}, 2'b00);
    m_rdat = 16'h0;
    for (int i = 0; i < 30; i++) begin
      cfg_fast_en = 2'($urandom);
      cfg_iordy_en = 2'($urandom);
      tim_dev0 = {8'($urandom), 8'($urandom_range(1, 6)), 8'($urandom_range(1, 6)), 8'($urandom_range(1, 6))};
      tim_dev1 = {8'($urandom), 8'($urandom_range(1, 6)), 8'($urandom_range(1, 6)), 8'($urandom_range(1, 6))};
      case ($urandom_range(0, 3))
        0: a = 4'h0;
        1: a = 4'h6;
        2: a = 4'hE;
        default: a = 4'($urandom);
      endcase
      we = 1'($urandom);
      d = 16'($urandom);
      di = 16'($urandom);
      t = m_tim(a);
      access(a, we, d, di, t, m_lat(t), m_next(a, we, d));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
